// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM between instruction fetch (IF) and data (D) ports.
// Optional BUSY timeout with abort/err is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          err,
  output logic          ram_en,
  output logic          ram_mov,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_moc
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, DONE} state_e;

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic          selD_q, selD_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    starve_q, starve_d;
  logic          active;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ToLast = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      selD_q   <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= 4'd0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      selD_q   <= selD_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // D has priority unless IF has waited through StarveLim consecutive D grants.
  always_comb begin
    state_d  = state_q;
    selD_d   = selD_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req && !(if_req && starve_q == StarveLim)) begin
          selD_d  = 1'b1;
          rw_d    = d_rw;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          if (!if_req)
            starve_d = 4'd0;
          else if (starve_q != StarveLim)
            starve_d = starve_q + 4'd1;
          state_d = GRANT;
        end else if (if_req) begin
          selD_d   = 1'b0;
          rw_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          starve_d = 4'd0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        state_d = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
      end
      BUSY: begin
        if (ram_moc) begin
          if (!rw_q)
            rdata_d = ram_rdata;
          state_d = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM side is decoded from state so a reset drops the handshake at once.
  assign active    = (state_q == GRANT) || (state_q == BUSY);
  assign ram_en    = active;
  assign ram_mov   = active;
  assign ram_rw    = active & rw_q;
  assign ram_addr  = active ? addr_q : '0;
  assign ram_wdata = active ? wdata_q : '0;

  assign if_done = (state_q == DONE) && !selD_q;
  assign d_done  = (state_q == DONE) && selD_q;
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err = (state_q == DONE) && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
// Define MEM_ARB_TIMEOUT_EN to also build and exercise the timeout abort (TIMEOUT=8).
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TimeoutP = 8;
`else
  localparam int TimeoutP = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] rdata;
  logic        busy;
  logic        err;
  logic        ram_en;
  logic        ram_mov;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_moc;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(TimeoutP)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .busy(busy), .err(err),
    .ram_en(ram_en), .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_moc(ram_moc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isD;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   passCount = 0;
  int   doneSeen = 0;
  int   mocDelay = 1;
  int   movCnt = 0;
  logic respMoc = 1'b0;
  logic forceMoc = 1'b0;
  logic autoDrop = 1'b1;
  int   contLeft = 0;

  // RAM model: fixed word at 0x40, otherwise address xor a tag
  assign ram_rdata = (ram_addr == 32'h40) ? 32'hDEADBEEF : (ram_addr ^ 32'hA5A5_0000);
  assign ram_moc   = respMoc | forceMoc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pushExp(input logic isD, input logic [31:0] data, input logic e);
    exp_t x;
    x.isD = isD; x.data = data; x.err = e;
    sbQ.push_back(x);
  endtask

  // Responder raises moc once ram_mov has been high for more than mocDelay cycles
  initial begin
    forever begin
      @(negedge clk);
      if (ram_mov) movCnt++;
      else movCnt = 0;
      respMoc = ram_mov && (movCnt > mocDelay);
    end
  end

  // Requesters drop their request at the done cycle
  initial begin
    forever begin
      @(negedge clk);
      if (if_done || d_done) begin
        if (contLeft > 0) begin
          contLeft--;
          if (contLeft == 0) begin
            if_req = 1'b0;
            d_req = 1'b0;
          end
        end else if (autoDrop) begin
          if (d_done) d_req = 1'b0;
          if (if_done) if_req = 1'b0;
        end
      end
    end
  end

  // Monitor: every done pulse is matched against the scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_done || d_done) begin
        doneSeen++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", {30'd0, if_done, d_done}, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb_d_done", {31'd0, d_done}, {31'd0, e.isD});
          checkOutput("sb_if_done", {31'd0, if_done}, {31'd0, !e.isD});
          checkOutput("sb_rdata", rdata, e.data);
          checkOutput("sb_err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic waitDones(input int target, input int budget);
    int k;
    k = 0;
    while (doneSeen < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (doneSeen < target)
      checkOutput("done_timeout", doneSeen, target);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
    checkOutput({tag, "_ram_mov"}, {31'd0, ram_mov}, 32'd0);
    checkOutput({tag, "_dones"}, {30'd0, if_done, d_done}, 32'd0);
  endtask

  task automatic applyStimulus();
    int k;
    int doneAt;

    // Reset state
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_ram_bus", ram_addr | ram_wdata | {31'd0, ram_rw}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single D read at minimum latency
    mocDelay = 1;
    d_rw = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    pushExp(1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    checkOutput("rd_grant_mov", {31'd0, ram_mov}, 32'd1);
    checkOutput("rd_grant_addr", ram_addr, 32'h40);
    @(negedge clk);
    checkOutput("rd_busy_mov", {31'd0, ram_mov}, 32'd1);
    checkOutput("rd_busy_done", {31'd0, d_done}, 32'd0);
    @(negedge clk);
    checkOutput("rd_done_pulse", {31'd0, d_done}, 32'd1);
    checkOutput("rd_done_mov", {31'd0, ram_mov}, 32'd0);
    @(negedge clk);
    checkIdleOutputs("rd_after");
    waitDones(1, 10);

    // D write with 5 extra wait cycles; inputs change after grant
    mocDelay = 6;
    d_rw = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; d_req = 1'b1;
    pushExp(1'b1, 32'hDEADBEEF, 1'b0);
    doneAt = 0;
    for (k = 1; k <= 20 && doneAt == 0; k++) begin
      @(negedge clk);
      if (ram_mov) begin
        checkOutput("wr_ram_rw", {31'd0, ram_rw}, 32'd1);
        checkOutput("wr_ram_wdata", ram_wdata, 32'h12345678);
        checkOutput("wr_ram_addr", ram_addr, 32'h80);
      end
      if (k == 1) begin
        d_wdata = 32'hFFFF_FFFF;
        d_addr = 32'h0;
      end
      if (d_done) doneAt = k;
    end
    checkOutput("wr_latency", doneAt, 8);
    waitDones(2, 10);
    d_rw = 1'b0;

    // IF request arriving during GRANT waits for IDLE
    mocDelay = 1;
    d_addr = 32'h44; d_req = 1'b1;
    pushExp(1'b1, 32'hA5A50044, 1'b0);
    pushExp(1'b0, 32'hA5A50100, 1'b0);
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    waitDones(4, 20);

    // Contention: both held for ten grants
    d_addr = 32'h40;
    for (int g = 0; g < 10; g++)
      pushExp((g % 5) != 4, ((g % 5) != 4) ? 32'hDEADBEEF : 32'hA5A50100, 1'b0);
    contLeft = 10;
    @(negedge clk);
    d_req = 1'b1; if_req = 1'b1;
    waitDones(14, 100);
    repeat (2) @(negedge clk);
    checkIdleOutputs("cont_after");

    // Spurious moc in IDLE
    for (int s = 0; s < 3; s++) begin
      forceMoc = 1'b1;
      @(negedge clk);
      checkIdleOutputs("spurious");
    end
    forceMoc = 1'b0;
    @(negedge clk);
    checkOutput("spurious_rdata", rdata, 32'hA5A50100);

`ifdef MEM_ARB_TIMEOUT_EN
    // IF access aborted after TIMEOUT BUSY cycles
    mocDelay = 1000;
    if_addr = 32'h200; if_req = 1'b1;
    pushExp(1'b0, 32'hA5A50100, 1'b1);
    doneAt = 0;
    for (k = 1; k <= 20 && doneAt == 0; k++) begin
      @(negedge clk);
      if (k == 9) checkOutput("to_last_busy_mov", {31'd0, ram_mov}, 32'd1);
      if (if_done) begin
        doneAt = k;
        checkOutput("to_err", {31'd0, err}, 32'd1);
        checkOutput("to_done_mov", {31'd0, ram_mov}, 32'd0);
      end
    end
    checkOutput("to_latency", doneAt, 10);
    waitDones(15, 10);
    mocDelay = 1;
    @(negedge clk);
`endif

    // Reset in 2nd BUSY cycle, then a late moc
    mocDelay = 20;
    d_rw = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_mov", {31'd0, ram_mov}, 32'd1);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    forceMoc = 1'b1;
    checkIdleOutputs("rst_mid");
    checkOutput("rst_mid_rdata", rdata, 32'd0);
    @(negedge clk);
    forceMoc = 1'b0;
    checkIdleOutputs("rst_late_moc");
    repeat (3) @(negedge clk);
    checkIdleOutputs("rst_settle");
  endtask

  initial begin
    applyStimulus();
    checkOutput("sb_empty", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0d dones", doneSeen);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
